// File: rtl/apb_master_bridge.sv
// APB3 initiator: turns a core req/gnt/rvalid interface into one APB transfer
// at a time, with slave wait states, PSLVERR and an optional access timeout.
module apb_master_bridge #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      req_i,
   output logic                      gnt_o,
   input  logic [APB_ADDR_WIDTH-1:0] addr_i,
   input  logic                      we_i,
   input  logic [31:0]               wdata_i,
   output logic                      rvalid_o,
   output logic [31:0]               rdata_o,
   output logic                      err_o,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_t;

   localparam logic [15:0] LP_TO = 16'(TIMEOUT_CYCLES);

   state_t                      r_state;
   logic [15:0]                 r_cnt;
   logic [APB_ADDR_WIDTH-1:0]   r_paddr;
   logic [31:0]                 r_pwdata;
   logic                        r_pwrite;
   logic                        r_psel;
   logic                        r_penable;
   logic                        r_rvalid;
   logic [31:0]                 r_rdata;
   logic                        r_err;
   logic [15:0]                 w_cnt_inc;
   logic                        w_timeout;

   assign gnt_o     = req_i && (r_state == S_IDLE);
   assign w_cnt_inc = r_cnt + 16'd1;
   // Abort on the ACCESS cycle that would bring the wait count to the limit
   assign w_timeout = (LP_TO != 16'd0) && !PREADY && (w_cnt_inc == LP_TO);

   assign PADDR    = r_paddr;
   assign PWDATA   = r_pwdata;
   assign PWRITE   = r_pwrite;
   assign PSEL     = r_psel;
   assign PENABLE  = r_penable;
   assign rvalid_o = r_rvalid;
   assign rdata_o  = r_rdata;
   assign err_o    = r_err;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state   <= S_IDLE;
         r_cnt     <= 16'd0;
         r_paddr   <= '0;
         r_pwdata  <= 32'd0;
         r_pwrite  <= 1'b0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= 32'd0;
         r_err     <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (gnt_o) begin
                  r_paddr  <= addr_i;
                  r_pwrite <= we_i;
                  r_pwdata <= wdata_i;
                  r_psel   <= 1'b1;
                  r_cnt    <= 16'd0;
                  r_state  <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (PREADY) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_err     <= PSLVERR;
                  r_rdata   <= r_pwrite ? 32'd0 : PRDATA;
                  r_state   <= S_IDLE;
               end else if (w_timeout) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_err     <= 1'b1;
                  r_rdata   <= 32'd0;
                  r_state   <= S_IDLE;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: begin
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB initiator: converts a simple core-side request/grant/response interface into APB3 transfers.
- Drives APB slaves such as the event unit and other 4KB peripheral slaves.
- Handles one outstanding transfer at a time, slave wait states (PREADY low) and PSLVERR.
- Optional access timeout so a hung slave cannot stall the core.

Parameters:
- APB_ADDR_WIDTH, 12: width of addr_i and PADDR (4KB slave space).
- TIMEOUT_CYCLES, 255: maximum ACCESS-phase cycles before abort. 0 disables the timeout. Range 0..65535; counter is 16 bits.

Ports:
- HCLK  input  1  clock.
- HRESETn  input  1  asynchronous active-low reset.
- req_i  input  1  core requests a transfer.
- gnt_o  output  1  request accepted this cycle.
- addr_i  input  APB_ADDR_WIDTH  transfer address.
- we_i  input  1  1 = write, 0 = read.
- wdata_i  input  32  write data.
- rvalid_o  output  1  one-cycle pulse: response valid.
- rdata_o  output  32  read data; valid with rvalid_o.
- err_o  output  1  slave error or timeout; valid with rvalid_o.
- PADDR  output  APB_ADDR_WIDTH  APB address.
- PWDATA  output  32  APB write data.
- PWRITE  output  1  APB direction.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PRDATA  input  32  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB slave error.

Behaviour:
- Clock and reset: single clock HCLK. Reset HRESETn is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Reset mid-transfer: PSEL and PENABLE drop immediately (asynchronously). The transfer is discarded and no rvalid_o is produced.
- States: IDLE, SETUP, ACCESS.
- gnt_o is combinational: req_i && state==IDLE.
- IDLE:
  - On req_i && gnt_o, register addr_i/we_i/wdata_i into PADDR/PWRITE/PWDATA, then go to SETUP.
  - PSEL=0, PENABLE=0.
  - PADDR/PWDATA/PWRITE hold their last values.
- SETUP: PSEL=1, PENABLE=0; always go to ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - PADDR/PWDATA/PWRITE stay stable for the whole transfer.
  - If PREADY=1: go to IDLE. Next cycle rvalid_o=1 and err_o=PSLVERR. rdata_o=PRDATA for reads, 0 for writes.
  - If PREADY=0: stay in ACCESS and increment the timeout counter.
  - PSLVERR is sampled only when PSEL && PENABLE && PREADY.
- Timeout: if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES while PREADY=0:
  - Go to IDLE, deasserting PSEL/PENABLE next cycle.
  - rvalid_o=1, err_o=1, rdata_o=0 in that same next cycle.
  - If PREADY=1 arrives in the same cycle the counter reaches its limit, the PREADY completion wins (normal response).
  - Counter clears on entry to SETUP.
- Response outputs: rvalid_o is a single-cycle pulse. rdata_o/err_o are registered and hold until the next response.
- Latency: grant at cycle 0, SETUP at 1, ACCESS at 2 (PREADY=1), rvalid_o at 3.
- Back-to-back: gnt_o may assert in the rvalid_o cycle. Minimum spacing between grants is 3 cycles.
- Outstanding transfers: at most one.
- Request persistence: req_i held while not granted is simply waited on; no requirement that req_i stays high until granted.
- Request inputs are ignored outside IDLE.
- Address width: addr_i is passed unaltered; no alignment check.

Test Plan:
- Write, zero-wait: addr=0x004, wdata=0x0000_00FF, PREADY=1.
  -> PSEL at cycle 1; PENABLE at cycle 2 with PADDR=0x004, PWRITE=1, PWDATA=0xFF; rvalid_o at cycle 3 with err_o=0, rdata_o=0.
- Read with 3 wait states: slave returns PRDATA=0x0000_0010 on the 4th ACCESS cycle.
  -> PENABLE high 4 cycles with address stable; rvalid_o exactly one cycle later with rdata_o=0x10.
- Slave error: read, PREADY=1 with PSLVERR=1.
  -> rvalid_o=1, err_o=1. Next transfer with PSLVERR=0 returns err_o=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0.
  -> After 4 ACCESS cycles PSEL/PENABLE drop; rvalid_o=1, err_o=1, rdata_o=0; gnt_o available again.
- Back-to-back with req_i held high: write 0x000 then read 0x008.
  -> grants at cycles 0 and 3; the second transfer's PSEL rises at cycle 4; gnt_o=0 in cycles 1-2.
- Reset during ACCESS (PREADY=0): assert HRESETn=0 mid-cycle.
  -> PSEL/PENABLE/rvalid_o go 0 without waiting for a clock edge; after release, state is IDLE and gnt_o follows req_i.
